// File: rtl/serial_byte_rcv.sv
// Serial byte receiver: start-edge detect, mid-bit sampling of 8 data bits
// LSB first plus stop bit, with a held output byte and ready/overrun/framing flags.
module serial_byte_rcv #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       data_read,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       framing_error,
  output logic       busy
);

  localparam logic [7:0] HALF_PERIOD = 8'(BIT_PERIOD / 2);
  localparam logic [7:0] FULL_PERIOD = 8'(BIT_PERIOD);

  typedef enum logic [1:0] {IDLE, START_CHK, DATA, STOP} state_t;

  state_t      r_state;
  logic        r_prev_bit;
  logic        r_armed;
  logic [7:0]  r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_data_ready;
  logic        r_overrun;
  logic        r_framing;
  logic        r_busy;

  state_t      w_state_next;
  logic [7:0]  w_cnt_next;
  logic [2:0]  w_bit_idx_next;
  logic        w_start;
  logic        w_cnt_done;
  logic        w_shift_en;
  logic        w_load;
  logic        w_frame_bad;

  // r_armed blocks start detection after reset until the line has been seen high.
  assign w_start    = r_armed & r_prev_bit & ~serial_in;
  assign w_cnt_done = (r_cnt == 8'd1);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_en     = 1'b0;
    w_load         = 1'b0;
    w_frame_bad    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = START_CHK;
          w_cnt_next   = HALF_PERIOD;
        end
      end
      START_CHK: begin
        if (w_cnt_done) begin
          if (!serial_in) begin
            w_state_next   = DATA;
            w_cnt_next     = FULL_PERIOD;
            w_bit_idx_next = 3'd0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      DATA: begin
        if (w_cnt_done) begin
          w_shift_en = 1'b1;
          w_cnt_next = FULL_PERIOD;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      STOP: begin
        if (w_cnt_done) begin
          w_state_next = IDLE;
          w_load       = serial_in;
          w_frame_bad  = ~serial_in;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_bit_idx <= 3'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  // A load beats a simultaneous acknowledge; a bad stop bit leaves the held byte alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_bit   <= 1'b1;
      r_armed      <= 1'b0;
      r_shift      <= 8'h00;
      r_rx_data    <= 8'h00;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_framing    <= 1'b0;
    end else begin
      r_prev_bit <= serial_in;
      r_armed    <= r_armed | serial_in;
      if (w_shift_en) begin
        r_shift <= {serial_in, r_shift[7:1]};
      end
      if (w_load) begin
        r_rx_data    <= r_shift;
        r_data_ready <= 1'b1;
        r_framing    <= 1'b0;
        if (r_data_ready && !data_read) begin
          r_overrun <= 1'b1;
        end
      end else begin
        if (w_frame_bad) begin
          r_framing <= 1'b1;
        end
        if (data_read && r_data_ready) begin
          r_data_ready <= 1'b0;
          r_overrun    <= 1'b0;
        end
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;
  assign busy          = r_busy;

endmodule

// File: doc/serial_byte_rcv.md
SERIAL_BYTE_RCV -- requirements
Module: serial_byte_rcv

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter BIT_PERIOD, default 10, meaning clocks per serial bit; legal range 4..255.
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port serial_in, input, 1, synchronized serial line from the upstream two-flop synchronizer; idle high.
REQ-006 SHALL have port data_read, input, 1, consumer acknowledge of the held byte.
REQ-007 SHALL have port rx_data, output, 8, last good received byte.
REQ-008 SHALL have port data_ready, output, 1, rx_data holds an unread byte.
REQ-009 SHALL have port overrun_error, output, 1, a byte was loaded while data_ready was already 1.
REQ-010 SHALL have port framing_error, output, 1, the last completed frame had stop bit 0.
REQ-011 SHALL have port busy, output, 1, a frame is in progress.

Function
REQ-012 SHALL register serial_in into prev_bit each cycle; the start edge E is the rising clk where prev_bit=1 and serial_in=0 while in IDLE.
REQ-013 SHALL implement states IDLE, START_CHK, DATA, STOP; busy=1 in every state except IDLE.
REQ-014 SHALL move IDLE->START_CHK at E and load the bit counter with BIT_PERIOD/2, using integer division.
REQ-015 SHALL sample serial_in at E+BIT_PERIOD/2; if 0, go to DATA; if 1, treat it as a false start and return to IDLE with no output change.
REQ-016 SHALL sample data bit i (i=0..7, LSB first) at E+BIT_PERIOD/2+(i+1)*BIT_PERIOD into an internal shift register, not into rx_data.
REQ-017 SHALL sample the stop bit at E+BIT_PERIOD/2+9*BIT_PERIOD, then return to IDLE on that same edge.
REQ-018 On a stop bit of 1, SHALL load rx_data from the shift register, set data_ready=1, and set framing_error=0.
REQ-019 On a stop bit of 0, SHALL set framing_error=1 and leave rx_data, data_ready and overrun_error unchanged.
REQ-020 SHALL set overrun_error=1 when REQ-018 fires while data_ready=1 and data_read=0; rx_data takes the new byte.
REQ-021 SHALL clear data_ready and overrun_error on the edge following data_read=1 when no load occurs on that edge.
REQ-022 If a load and data_read=1 coincide on one edge, the load SHALL win: data_ready=1, overrun_error unchanged.
REQ-023 SHALL ignore serial_in transitions outside the sample edges; a glitch between samples has no effect.
REQ-024 SHALL accept a new start edge on the first cycle after returning to IDLE (back-to-back frames), with prev_bit supplying the edge history.
REQ-025 SHALL ignore data_read=1 when data_ready=0.
REQ-026 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-027 When rst=1, SHALL asynchronously force IDLE, prev_bit=1, shift register=0, rx_data=8'h00, data_ready=0, overrun_error=0, framing_error=0, busy=0.
REQ-028 A mid-frame rst SHALL abandon the frame with no partial load, and SHALL detect no start edge until serial_in has been seen high after rst deasserts.
REQ-029 Outputs SHALL hold reset values while rst=1 regardless of clk or serial_in activity.

Verification (BIT_PERIOD=10)
REQ-030 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> at E+95: rx_data=0xA5, data_ready=1, framing_error=0; busy=0 the cycle after.
REQ-031 serial_in low for 3 cycles then high -> false start at E+5; data_ready stays 0, rx_data unchanged, busy returns to 0.
REQ-032 Frame 0x3C with stop bit 0 -> framing_error=1 at E+95; data_ready=0, rx_data keeps its prior value; a following good frame 0x11 clears framing_error.
REQ-033 Frames 0x12 then 0x34 with no data_read -> rx_data=0x34, data_ready=1, overrun_error=1; data_read pulse -> both flags 0 on the next edge.
REQ-034 rst asserted at E+40 of frame 0xFF -> all outputs 0 immediately; after release, a clean frame 0x5A is received correctly.
REQ-035 data_read=1 on the exact load edge of frame 0x77 while data_ready=1 -> data_ready=1, rx_data=0x77, overrun_error=0.
